// File: rtl/reg_file_wb_sched_if.sv
// Writeback bus between the P/M/L sources, the issue stage and the register file write port.
// The scheduler takes the slave view; whoever drives the sources takes the master view.
interface reg_file_wb_sched_if #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5
);
  logic                   p_we;
  logic                   p_squashn;
  logic [LOG2NUMREGS-1:0] p_reg;
  logic [WIDTH-1:0]       p_data;
  logic                   p_stall;
  logic                   m_valid;
  logic                   m_ready;
  logic [LOG2NUMREGS-1:0] m_reg;
  logic [WIDTH-1:0]       m_data;
  logic                   l_valid;
  logic                   l_ready;
  logic [LOG2NUMREGS-1:0] l_reg;
  logic [WIDTH-1:0]       l_data;
  logic                   issue_en;
  logic [LOG2NUMREGS-1:0] issue_reg;
  logic                   issue_busy;
  logic [LOG2NUMREGS-1:0] a_reg;
  logic [LOG2NUMREGS-1:0] b_reg;
  logic                   a_busy;
  logic                   b_busy;
  logic                   c_we;
  logic                   c_squashn;
  logic [LOG2NUMREGS-1:0] c_reg;
  logic [WIDTH-1:0]       c_writedatain;

  modport slave (
    input  p_we, p_squashn, p_reg, p_data,
    output p_stall,
    input  m_valid, m_reg, m_data,
    output m_ready,
    input  l_valid, l_reg, l_data,
    output l_ready,
    input  issue_en, issue_reg, a_reg, b_reg,
    output issue_busy, a_busy, b_busy,
    output c_we, c_squashn, c_reg, c_writedatain
  );

  modport master (
    output p_we, p_squashn, p_reg, p_data,
    input  p_stall,
    output m_valid, m_reg, m_data,
    input  m_ready,
    output l_valid, l_reg, l_data,
    input  l_ready,
    output issue_en, issue_reg, a_reg, b_reg,
    input  issue_busy, a_busy, b_busy,
    input  c_we, c_squashn, c_reg, c_writedatain
  );
endinterface

// File: rtl/reg_file_wb_sched.sv
// Shares the register file write port among pipeline (P), mul/div (M) and load (L) writeback,
// and keeps a pending-write scoreboard for RAW/WAW stalls on long-latency destinations.
module reg_file_wb_sched #(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LOG2NUMREGS  = 5,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               resetn,
  reg_file_wb_sched_if.slave bus
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  logic                   r_rr_l;
  logic [7:0]             r_starve_cnt;
  logic [NUMREGS-1:0]     r_pending;
  logic                   r_c_we;
  logic                   r_c_squashn;
  logic [LOG2NUMREGS-1:0] r_c_reg;
  logic [WIDTH-1:0]       r_c_data;
  logic                   r_p_stall;

  logic                   w_p_win;
  logic                   w_m_gnt;
  logic                   w_l_gnt;
  logic                   w_ml_gnt;
  logic                   w_wait;
  logic [LOG2NUMREGS-1:0] w_ml_reg;
  logic [LOG2NUMREGS-1:0] w_gnt_reg;
  logic [WIDTH-1:0]       w_gnt_data;
  logic [NUMREGS-1:0]     w_pend_nxt;

  // Arbitration: P first, then round-robin M/L; nothing is granted while in reset
  always_comb begin
    w_p_win = bus.p_we & bus.p_squashn;
    w_m_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (resetn && !w_p_win) begin
      if (bus.m_valid && bus.l_valid) begin
        w_m_gnt = ~r_rr_l;
        w_l_gnt = r_rr_l;
      end else begin
        w_m_gnt = bus.m_valid;
        w_l_gnt = bus.l_valid;
      end
    end
    w_ml_gnt   = w_m_gnt | w_l_gnt;
    w_ml_reg   = w_m_gnt ? bus.m_reg  : bus.l_reg;
    w_gnt_reg  = w_p_win ? bus.p_reg  : w_ml_reg;
    w_gnt_data = w_p_win ? bus.p_data : (w_m_gnt ? bus.m_data : bus.l_data);
    w_wait     = (bus.m_valid | bus.l_valid) & ~w_ml_gnt;
  end

  // A new issue to the same register outranks the clear from its older write
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_ml_gnt) w_pend_nxt[w_ml_reg] = 1'b0;
    if (bus.issue_en) w_pend_nxt[bus.issue_reg] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Stage boundary: grant -> register file write port
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_c_we       <= 1'b0;
      r_c_squashn  <= 1'b1;
      r_c_reg      <= '0;
      r_c_data     <= '0;
      r_p_stall    <= 1'b0;
      r_pending    <= '0;
      r_rr_l       <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_c_squashn <= 1'b1;
      if (w_p_win || w_ml_gnt) begin
        r_c_we   <= (w_gnt_reg != '0);
        r_c_reg  <= w_gnt_reg;
        r_c_data <= w_gnt_data;
      end else begin
        r_c_we <= 1'b0;
      end
      if (w_ml_gnt) r_rr_l <= w_m_gnt;
      r_pending <= w_pend_nxt;
      if (!w_wait) begin
        r_starve_cnt <= '0;
        r_p_stall    <= 1'b0;
      end else if (r_starve_cnt == STARVE_MAX) begin
        r_p_stall <= 1'b1;
      end else begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  assign bus.m_ready       = w_m_gnt;
  assign bus.l_ready       = w_l_gnt;
  assign bus.p_stall       = r_p_stall;
  assign bus.c_we          = r_c_we;
  assign bus.c_squashn     = r_c_squashn;
  assign bus.c_reg         = r_c_reg;
  assign bus.c_writedatain = r_c_data;
  assign bus.issue_busy    = r_pending[bus.issue_reg];
  assign bus.a_busy        = r_pending[bus.a_reg];
  assign bus.b_busy        = r_pending[bus.b_reg];

endmodule
